// File: rtl/pintador_grid.sv
// pintador_grid: splits the active VGA area into a COLS x ROWS grid of colour
// registers and highlights one selectable tile; fixed 2-cycle pixel latency.
module pintador_grid #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int COLS         = 2,
    parameter int ROWS         = 2,
    parameter int BLINK_FRAMES = 30,
    parameter int BORDER       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic        wr_en,
    input  logic [3:0]  wr_tile,
    input  logic [23:0] wr_color,
    input  logic        sel_en,
    input  logic [3:0]  sel_tile,
    input  logic [1:0]  mode,
    output logic        wr_err,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int TW      = H_RES / COLS;
    localparam int TH      = V_RES / ROWS;
    localparam int NT      = COLS * ROWS;
    localparam int LAST_TW = H_RES - (COLS - 1) * TW;
    localparam int LAST_TH = V_RES - (ROWS - 1) * TH;
    localparam int CW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [1:0]    col_c;
    logic [1:0]    row_c;
    logic [3:0]    tile_c;
    logic [9:0]    xoff_c;
    logic [9:0]    yoff_c;
    logic          valid_c;

    logic [1:0]    s1_col;
    logic [1:0]    s1_row;
    logic [3:0]    s1_tile;
    logic [9:0]    s1_xoff;
    logic [9:0]    s1_yoff;
    logic          s1_valid;

    logic [23:0]   color_table [16];
    logic [3:0]    active_tile;
    logic [CW-1:0] blink_cnt;
    logic          blink_phase;
    logic          wr_bad;
    logic          sel_bad;

    logic [23:0]   tile_color;
    logic [9:0]    tile_w;
    logic [9:0]    tile_h;
    logic          near_edge;
    logic          is_active;
    logic [23:0]   pixel_c;

    // Tile location by comparison against fixed boundaries; the last
    // column/row absorbs any remainder pixels.
    always_comb begin
        col_c  = '0;
        xoff_c = x;
        for (int c = 1; c < COLS; c++) begin
            if (x >= 10'(c * TW)) begin
                col_c  = 2'(c);
                xoff_c = x - 10'(c * TW);
            end
        end
        row_c  = '0;
        yoff_c = y;
        for (int rr = 1; rr < ROWS; rr++) begin
            if (y >= 10'(rr * TH)) begin
                row_c  = 2'(rr);
                yoff_c = y - 10'(rr * TH);
            end
        end
        tile_c  = 4'(row_c) * 4'(COLS) + 4'(col_c);
        valid_c = video_on && ({1'b0, x} < 11'(H_RES)) && ({1'b0, y} < 11'(V_RES));
        wr_bad  = wr_en && ({1'b0, wr_tile} >= 5'(NT));
        sel_bad = sel_en && ({1'b0, sel_tile} >= 5'(NT));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_col   <= '0;
            s1_row   <= '0;
            s1_tile  <= '0;
            s1_xoff  <= '0;
            s1_yoff  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_col   <= col_c;
            s1_row   <= row_c;
            s1_tile  <= tile_c;
            s1_xoff  <= xoff_c;
            s1_yoff  <= yoff_c;
            s1_valid <= valid_c;
        end
    end

    // Stage 2 reads the table as it was before this edge, so a same-edge
    // write is only visible to the following pixel.
    always_comb begin
        tile_color = color_table[s1_tile];
        tile_w     = (s1_col == 2'(COLS - 1)) ? 10'(LAST_TW) : 10'(TW);
        tile_h     = (s1_row == 2'(ROWS - 1)) ? 10'(LAST_TH) : 10'(TH);
        near_edge  = ({1'b0, s1_xoff} < 11'(BORDER)) ||
                     ({1'b0, s1_xoff} + 11'(BORDER) >= {1'b0, tile_w}) ||
                     ({1'b0, s1_yoff} < 11'(BORDER)) ||
                     ({1'b0, s1_yoff} + 11'(BORDER) >= {1'b0, tile_h});
        is_active  = (s1_tile == active_tile);
        pixel_c    = tile_color;
        case (mode)
            2'd0: pixel_c = tile_color;
            2'd1: pixel_c = is_active ? tile_color : 24'h000000;
            2'd2: pixel_c = (is_active && blink_phase) ? ~tile_color : tile_color;
            2'd3: pixel_c = (is_active && near_edge) ? 24'hFFFFFF : tile_color;
        endcase
        if (!s1_valid) begin
            pixel_c = 24'h000000;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= pixel_c[23:16];
            g <= pixel_c[15:8];
            b <= pixel_c[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                color_table[i] <= '0;
            end
        end else if (wr_en && !wr_bad) begin
            color_table[wr_tile] <= wr_color;
        end
    end

    // Blink phase toggles once every BLINK_FRAMES frame_start pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_tile <= '0;
            wr_err      <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (sel_en && !sel_bad) begin
                active_tile <= sel_tile;
            end
            if (wr_bad || sel_bad) begin
                wr_err <= 1'b1;
            end
            if (frame_start) begin
                if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pintador_grid.sv
// Directed bench for pintador_grid: a 2x2 instance with a fast blink and a
// 3x1 instance for remainder-column and out-of-range behaviour.
module tb_pintador_grid;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        frame_start;
    logic        wr_en;
    logic [3:0]  wr_tile;
    logic [23:0] wr_color;
    logic        sel_en;
    logic [3:0]  sel_tile;
    logic [1:0]  mode;
    logic        wr_err;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    logic        wr_en3;
    logic [3:0]  wr_tile3;
    logic [23:0] wr_color3;
    logic        sel_en3;
    logic        wr_err3;
    logic [7:0]  r3;
    logic [7:0]  g3;
    logic [7:0]  b3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pintador_grid #(
        .H_RES(640), .V_RES(480), .COLS(2), .ROWS(2), .BLINK_FRAMES(2), .BORDER(4)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_start(frame_start), .wr_en(wr_en), .wr_tile(wr_tile),
        .wr_color(wr_color), .sel_en(sel_en), .sel_tile(sel_tile), .mode(mode),
        .wr_err(wr_err), .r(r), .g(g), .b(b)
    );

    pintador_grid #(
        .H_RES(640), .V_RES(480), .COLS(3), .ROWS(1), .BLINK_FRAMES(2), .BORDER(4)
    ) dut3 (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_start(frame_start), .wr_en(wr_en3), .wr_tile(wr_tile3),
        .wr_color(wr_color3), .sel_en(sel_en3), .sel_tile(sel_tile), .mode(mode),
        .wr_err(wr_err3), .r(r3), .g(g3), .b(b3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tile(input logic [3:0] t, input logic [23:0] c);
        wr_en = 1'b1; wr_tile = t; wr_color = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_tile3(input logic [3:0] t, input logic [23:0] c);
        wr_en3 = 1'b1; wr_tile3 = t; wr_color3 = c;
        tick();
        wr_en3 = 1'b0;
    endtask

    task automatic select_tile(input logic [3:0] t);
        sel_en = 1'b1; sel_tile = t;
        tick();
        sel_en = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        video_on = 1'b1;
        x = 10'($urandom_range(0, 639));
        y = 10'($urandom_range(0, 479));
        repeat (3) tick();
        tests_run++;
        if ({r, g, b} !== 24'h000000) begin
            $display("[TB] FAIL reset_rgb: got %h expected 000000", {r, g, b});
            tests_failed++;
        end
        tests_run++;
        if (wr_err !== 1'b0 || wr_err3 !== 1'b0) begin
            $display("[TB] FAIL reset_wr_err: got %b/%b expected 0/0", wr_err, wr_err3);
            tests_failed++;
        end
        reset = 1'b1;
        mode = 2'd0;
        x = 10'd100; y = 10'd100;
        tick(); tick();
        tests_run++;
        if ({r, g, b} !== 24'h000000 || {r3, g3, b3} !== 24'h000000) begin
            $display("[TB] FAIL reset_table: got %h/%h expected 000000", {r, g, b}, {r3, g3, b3});
            tests_failed++;
        end
    endtask

    task automatic test_mode0();
        logic [9:0]  xs [6];
        logic [9:0]  ys [6];
        logic        vs [6];
        logic [23:0] ex [6];
        xs = '{10'd319, 10'd320, 10'd319, 10'd320, 10'd700, 10'd639};
        ys = '{10'd239, 10'd239, 10'd240, 10'd240, 10'd300, 10'd479};
        vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ex = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF00FF, 24'h000000, 24'hFF00FF};
        write_tile(4'd0, 24'hFF0000);
        write_tile(4'd1, 24'h00FF00);
        write_tile(4'd2, 24'h0000FF);
        write_tile(4'd3, 24'hFF00FF);
        mode = 2'd0;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                x = xs[i]; y = ys[i]; video_on = vs[i];
            end
            tick();
            if (i > 0) begin
                tests_run++;
                if ({r, g, b} !== ex[i-1]) begin
                    $display("[TB] FAIL mode0_px%0d: got %h expected %h", i - 1, {r, g, b}, ex[i-1]);
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_mode1();
        logic [9:0]  xs [6];
        logic [9:0]  ys [6];
        logic        vs [6];
        logic [23:0] ex [6];
        xs = '{10'd100, 10'd400, 10'd100, 10'd400, 10'd319, 10'd10};
        ys = '{10'd300, 10'd300, 10'd100, 10'd100, 10'd240, 10'd300};
        vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex = '{24'h0000FF, 24'h000000, 24'h000000, 24'h000000, 24'h0000FF, 24'h000000};
        select_tile(4'd2);
        mode = 2'd1;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                x = xs[i]; y = ys[i]; video_on = vs[i];
            end
            tick();
            if (i > 0) begin
                tests_run++;
                if ({r, g, b} !== ex[i-1]) begin
                    $display("[TB] FAIL mode1_px%0d: got %h expected %h", i - 1, {r, g, b}, ex[i-1]);
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_cols3();
        logic [9:0]  xs [5];
        logic [23:0] ex [5];
        xs = '{10'd212, 10'd213, 10'd425, 10'd426, 10'd639};
        ex = '{24'h111111, 24'h222222, 24'h222222, 24'h333333, 24'h333333};
        mode = 2'd0;
        video_on = 1'b1;
        y = 10'd100;
        write_tile3(4'd0, 24'h111111);
        write_tile3(4'd1, 24'h222222);
        write_tile3(4'd2, 24'h333333);
        tests_run++;
        if (wr_err3 !== 1'b0) begin
            $display("[TB] FAIL cols3_no_err: got %b expected 0", wr_err3);
            tests_failed++;
        end
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) x = xs[i];
            tick();
            if (i > 0) begin
                tests_run++;
                if ({r3, g3, b3} !== ex[i-1]) begin
                    $display("[TB] FAIL cols3_x%0d: got %h expected %h", xs[i-1], {r3, g3, b3}, ex[i-1]);
                    tests_failed++;
                end
            end
        end
        write_tile3(4'd3, 24'h444444);
        tests_run++;
        if (wr_err3 !== 1'b1) begin
            $display("[TB] FAIL cols3_oob_err: got %b expected 1", wr_err3);
            tests_failed++;
        end
        x = 10'd639;
        tick(); tick();
        tests_run++;
        if ({r3, g3, b3} !== 24'h333333) begin
            $display("[TB] FAIL cols3_oob_nowrite: got %h expected 333333", {r3, g3, b3});
            tests_failed++;
        end
    endtask

    task automatic test_blink();
        logic [23:0] ex [4];
        int          pulses [4];
        ex = '{24'h123456, 24'h123456, 24'hEDCBA9, 24'h123456};
        pulses = '{0, 1, 1, 2};
        write_tile(4'd0, 24'h123456);
        select_tile(4'd0);
        mode = 2'd2;
        video_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < pulses[i]; p++) pulse_frame();
            x = 10'd100; y = 10'd100;
            tick(); tick();
            tests_run++;
            if ({r, g, b} !== ex[i]) begin
                $display("[TB] FAIL blink_step%0d: got %h expected %h", i, {r, g, b}, ex[i]);
                tests_failed++;
            end
            if (i == 2) begin
                x = 10'd400;
                tick(); tick();
                tests_run++;
                if ({r, g, b} !== 24'h00FF00) begin
                    $display("[TB] FAIL blink_other_tile: got %h expected 00ff00", {r, g, b});
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_border();
        logic [9:0]  xs [7];
        logic [9:0]  ys [7];
        logic [23:0] ex [7];
        xs = '{10'd320, 10'd323, 10'd324, 10'd100, 10'd639, 10'd400, 10'd400};
        ys = '{10'd240, 10'd300, 10'd300, 10'd100, 10'd479, 10'd476, 10'd475};
        ex = '{24'hFFFFFF, 24'hFFFFFF, 24'h00FF00, 24'h123456, 24'hFFFFFF, 24'hFFFFFF, 24'h00FF00};
        write_tile(4'd3, 24'h00FF00);
        select_tile(4'd3);
        mode = 2'd3;
        video_on = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                x = xs[i]; y = ys[i];
            end
            tick();
            if (i > 0) begin
                tests_run++;
                if ({r, g, b} !== ex[i-1]) begin
                    $display("[TB] FAIL border_px%0d: got %h expected %h", i - 1, {r, g, b}, ex[i-1]);
                    tests_failed++;
                end
            end
        end
        x = 10'd400; y = 10'd300;
        tick();
        x = 10'd401;
        wr_en = 1'b1; wr_tile = 4'd3; wr_color = 24'h0000FF;
        tick();
        wr_en = 1'b0;
        tests_run++;
        if ({r, g, b} !== 24'h00FF00) begin
            $display("[TB] FAIL write_edge_old: got %h expected 00ff00", {r, g, b});
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({r, g, b} !== 24'h0000FF) begin
            $display("[TB] FAIL write_edge_new: got %h expected 0000ff", {r, g, b});
            tests_failed++;
        end
    endtask

    task automatic test_errors();
        tests_run++;
        if (wr_err !== 1'b0) begin
            $display("[TB] FAIL err_clean: got %b expected 0", wr_err);
            tests_failed++;
        end
        select_tile(4'd5);
        tests_run++;
        if (wr_err !== 1'b1) begin
            $display("[TB] FAIL sel_oob_err: got %b expected 1", wr_err);
            tests_failed++;
        end
        x = 10'd320; y = 10'd240;
        tick(); tick();
        tests_run++;
        if ({r, g, b} !== 24'hFFFFFF) begin
            $display("[TB] FAIL sel_oob_keeps_active: got %h expected ffffff", {r, g, b});
            tests_failed++;
        end
        write_tile(4'd4, 24'hABCDEF);
        x = 10'd400; y = 10'd300;
        tick(); tick();
        tests_run++;
        if ({r, g, b} !== 24'h0000FF || wr_err !== 1'b1) begin
            $display("[TB] FAIL wr_oob: got %h/%b expected 0000ff/1", {r, g, b}, wr_err);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0;
        video_on = 1'b1;
        x = 10'd400; y = 10'd300;
        tick(); tick();
        tests_run++;
        if ({r, g, b} !== 24'h0000FF) begin
            $display("[TB] FAIL pre_reset: got %h expected 0000ff", {r, g, b});
            tests_failed++;
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if ({r, g, b} !== 24'h000000 || wr_err !== 1'b0) begin
            $display("[TB] FAIL mid_reset: got %h/%b expected 000000/0", {r, g, b}, wr_err);
            tests_failed++;
        end
        reset = 1'b1;
        video_on = 1'b0;
        write_tile(4'd3, 24'hABCDEF);
        video_on = 1'b1;
        tick();
        tests_run++;
        if ({r, g, b} !== 24'h000000) begin
            $display("[TB] FAIL post_reset_lat1: got %h expected 000000", {r, g, b});
            tests_failed++;
        end
        tick();
        tests_run++;
        if ({r, g, b} !== 24'hABCDEF) begin
            $display("[TB] FAIL post_reset_lat2: got %h expected abcdef", {r, g, b});
            tests_failed++;
        end
    endtask

    initial begin
        reset = 1'b0;
        x = '0; y = '0; video_on = 1'b0; frame_start = 1'b0;
        wr_en = 1'b0; wr_tile = '0; wr_color = '0;
        sel_en = 1'b0; sel_tile = '0; mode = 2'd0;
        wr_en3 = 1'b0; wr_tile3 = '0; wr_color3 = '0; sel_en3 = 1'b0;
        test_reset();
        test_mode0();
        test_mode1();
        test_cols3();
        test_blink();
        test_border();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pintador_grid.md
Name: pintador_grid

Overview:
Parametrised successor of the quadrant painter. It divides the active VGA area into a COLS x ROWS grid of tiles, each with a writable 24-bit colour register, and highlights one selectable tile in one of four display modes. A frame-synchronous blink timer drives the blink mode. The block sits between the VGA timing generator (x, y, video_on, frame_start) and the DAC outputs r/g/b, with a fixed 2-cycle pipeline latency.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
COLS, 2, tile columns (1..4)
ROWS, 2, tile rows (1..4)
BLINK_FRAMES, 30, frames per blink half-period (>=1)
BORDER, 4, highlight border thickness in pixels (mode 3)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-low reset
x  in  10  current pixel column
y  in  10  current pixel row
video_on  in  1  high inside active area
frame_start  in  1  one-cycle pulse at start of each frame
wr_en  in  1  colour-table write strobe
wr_tile  in  4  tile index to write (row*COLS+col)
wr_color  in  24  {R,G,B} to store
sel_en  in  1  load new active tile
sel_tile  in  4  active tile index
mode  in  2  display mode
wr_err  out  1  sticky: out-of-range write or select attempted
r  out  8  red
g  out  8  green
b  out  8  blue

Behaviour:
- Clock clk; reset is synchronous, active-low: reset==0 at a clk edge clears all state on that edge.
- Reset values: r=g=b=0, wr_err=0, all colour registers 0, active tile 0, blink counter 0, blink_phase 0, both pipeline stages invalid (output black).
- Tile width TW=H_RES/COLS, height TH=V_RES/ROWS (integer division). col = largest c<COLS with x>=c*TW; row likewise. Remainder pixels go to the last column/row. No dividers: compare against constant boundaries.
- Stage 1 (edge n): register col, row, tile index, in-tile offsets (x-col*TW, y-row*TH), and valid = video_on && x<H_RES && y<V_RES.
- Stage 2 (edge n+1): look up colour, apply mode, register r/g/b. Pixel presented at cycle n appears on r/g/b after edge n+1 (latency 2).
- Invalid pixel (valid=0): r=g=b=0 regardless of mode.
- Modes (T = pixel tile, A = active tile, C = colour[T]):
  0: output C for every tile.
  1: output C if T==A, else black (generalisation of the quadrant painter).
  2: output C for T!=A; for T==A output C when blink_phase=0, ~C (bitwise invert) when blink_phase=1.
  3: output C; if T==A and the pixel is within BORDER pixels of any tile edge, output 24'hFFFFFF.
- mode is sampled in stage 2; a change takes effect for the pixel in stage 2 on the next edge. No frame alignment.
- Writes: wr_en with wr_tile<COLS*ROWS updates colour[wr_tile] on that edge. Stage 2 samples the table before the edge, so a pixel whose lookup occurs on the write edge gets the old value. wr_tile>=COLS*ROWS: no write, wr_err<=1.
- Select: sel_en with sel_tile<COLS*ROWS loads A. An out-of-range index keeps A and sets wr_err. If wr_en and sel_en assert together, both act independently; errors OR into wr_err.
- wr_err clears only on reset.
- Blink: on frame_start, counter increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. Without frame_start pulses, blink_phase holds.
- Reset asserted mid-frame: outputs are black from the next edge. After release, the first valid pixel reaches r/g/b after 2 edges.

Test Plan:
- Reset: hold reset=0 for 3 clocks with video_on=1 and random x/y -> r=g=b=0, wr_err=0. After release with mode 0, all pixels are black (table cleared).
- Default 2x2, mode 0: write tiles 0..3 = FF0000, 00FF00, 0000FF, FF00FF. Drive (319,239), (320,239), (319,240), (320,240) -> those four colours exactly 2 cycles after each input.
- Mode 1, sel_tile=2 -> only pixels with x<320, y>=240 show 0000FF; all others 000000. video_on=0 at (10,300) -> black.
- COLS=3, ROWS=1, H_RES=640: x=212 -> tile 0, x=213 -> tile 1, x=639 -> tile 2 (remainder). Write wr_tile=3 -> ignored, wr_err=1.
- Mode 2, BLINK_FRAMES=2, tile 0=123456: after 0/1 frame_start pulses output 123456; after 2 pulses EDCBA9; after 4 pulses 123456 again.
- Mode 3, BORDER=4, A=3, colour 00FF00: (320,240) and (323,300) -> FFFFFF; (324,300) -> 00FF00; (100,100) -> tile-0 colour. A write to tile 3 on the lookup edge outputs the old value for that pixel and the new value on the next pixel.
